matrix_reader: RTL and testbench

//  Read-side initiator for the matrix memory. On start, walks a ROW x COLUMN matrix

---
 rtl/matrix_reader.sv | 147 ++++++++++++++
 tb/tb_matrix_reader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/matrix_reader.sv
// matrix_reader
//   Read-side initiator for the matrix memory. On start it walks a ROW x COLUMN
//   matrix held at base_addr and issues one memory read per element. The
//   asynchronous read data is captured and streamed out over valid/ready, in
//   row-major (operand A) or column-major (operand B) order.
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   start, col_major,
//   base_addr                start request, order select, matrix base address
//                            (the last two are latched when start is accepted)
//   busy, done               busy from accepted start through DONE; done pulse
//   mem_read, mem_addr,
//   mem_data                 memory read port (data valid in the mem_read cycle)
//   out_valid, out_ready     element handshake
//   out_data, out_row,
//   out_col, out_last        element value, its (row,col), final-element flag
module matrix_reader #(
  parameter int ROW    = 2,
  parameter int COLUMN = 2,
  parameter int SIZE   = 8,
  parameter int AW     = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            col_major,
  input  logic [AW-1:0]   base_addr,
  output logic            busy,
  output logic            done,
  output logic            mem_read,
  output logic [AW-1:0]   mem_addr,
  input  logic [SIZE-1:0] mem_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_data,
  output logic [AW-1:0]   out_row,
  output logic [AW-1:0]   out_col,
  output logic            out_last
);

  localparam logic [AW-1:0] R_LAST = AW'(ROW - 1);
  localparam logic [AW-1:0] C_LAST = AW'(COLUMN - 1);
  localparam logic [AW-1:0] COLS   = AW'(COLUMN);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

  state_t        state;
  logic          cm_q;
  logic [AW-1:0] base_q;
  logic [AW-1:0] r, c;       // index of the element the next read fetches
  logic [AW-1:0] addr_q;     // address of (r,c); also the visible mem_addr
  logic [AW-1:0] nr, nc, addr_next;
  logic          is_final;
  logic          fire;

  // A read is issued in FETCH, and in HOLD on the very cycle the current
  // element is accepted so the stream runs at one element per cycle.
  assign fire     = (state == FETCH) ||
                    (state == HOLD && out_valid && out_ready && !out_last);
  assign mem_read = fire;
  assign mem_addr = addr_q;
  assign is_final = (r == R_LAST) && (c == C_LAST);

  always_comb begin
    nr = r;
    nc = c;
    if (!cm_q) begin
      if (c == C_LAST) begin
        nc = '0;
        nr = r + AW'(1);
      end else begin
        nc = c + AW'(1);
      end
    end else begin
      if (r == R_LAST) begin
        nr = '0;
        nc = c + AW'(1);
      end else begin
        nr = r + AW'(1);
      end
    end
    // Modular address arithmetic: a matrix running past the top of memory wraps.
    addr_next = base_q + nr * COLS + nc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cm_q      <= 1'b0;
      base_q    <= '0;
      r         <= '0;
      c         <= '0;
      addr_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            cm_q   <= col_major;
            base_q <= base_addr;
            r      <= '0;
            c      <= '0;
            addr_q <= base_addr;
            busy   <= 1'b1;
            state  <= FETCH;
          end
        end
        FETCH: state <= HOLD;
        HOLD: begin
          if (out_valid && out_ready && out_last) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (fire) begin
        out_data  <= mem_data;
        out_row   <= r;
        out_col   <= c;
        out_last  <= is_final;
        out_valid <= 1'b1;
        // Indices stop on the final element so mem_addr keeps its last value.
        if (!is_final) begin
          r      <= nr;
          c      <= nc;
          addr_q <= addr_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_reader.sv
module tb_matrix_reader;
  localparam int ROW    = 2;
  localparam int COLUMN = 2;
  localparam int SIZE   = 8;
  localparam int AW     = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            col_major;
  logic [AW-1:0]   base_addr;
  logic            busy;
  logic            done;
  logic            mem_read;
  logic [AW-1:0]   mem_addr;
  logic [SIZE-1:0] mem_data;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] out_data;
  logic [AW-1:0]   out_row;
  logic [AW-1:0]   out_col;
  logic            out_last;

  logic [SIZE-1:0] mem [64];
  int tests = 0;
  int fails = 0;

  matrix_reader #(.ROW(ROW), .COLUMN(COLUMN), .SIZE(SIZE), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .col_major(col_major),
    .base_addr(base_addr), .busy(busy), .done(done), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_data(mem_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_col(out_col), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Asynchronous memory: data follows the address in the same cycle.
  assign mem_data = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one matrix read from the current (IDLE) cycle. rmode: 0 ready always,
  // 1 ready toggling, 2 ready random. abort_idx >= 0 stops the run while that
  // element is being held (ready forced low) and returns in that cycle.
  task automatic run_matrix(input logic [AW-1:0] base, input bit cm, input int rmode,
                            input bit hold_start, input int abort_idx);
    int er[$], ec[$], ea[$];
    int n, idx, aidx, k;
    bit fin;
    if (!cm) begin
      for (int i = 0; i < ROW; i++)
        for (int j = 0; j < COLUMN; j++) begin er.push_back(i); ec.push_back(j); end
    end else begin
      for (int j = 0; j < COLUMN; j++)
        for (int i = 0; i < ROW; i++) begin er.push_back(i); ec.push_back(j); end
    end
    foreach (er[i]) ea.push_back((int'(base) + er[i] * COLUMN + ec[i]) % 64);
    n = ROW * COLUMN;
    idx = 0; aidx = 0; k = 0; fin = 0;
    start = 1'b1; col_major = cm; base_addr = base; out_ready = 1'b0;
    while (!fin && k < 100) begin
      @(posedge clk); #1;
      k++;
      start = hold_start;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = k[0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (idx == abort_idx) out_ready = 1'b0;
      #1;
      check("busy", busy, 1);
      if (mem_read) begin
        if (aidx < n) check("mem_addr", mem_addr, ea[aidx]);
        else check("extra_read", 1, 0);
        aidx++;
      end
      if (k == 1) check("valid_at_fetch", out_valid, 0);
      if (k == 2) check("first_valid_latency", out_valid, 1);
      if (out_valid) begin
        if (idx >= n) check("extra_element", 1, 0);
        else begin
          check("out_data", out_data, mem[ea[idx]]);
          check("out_row", out_row, er[idx]);
          check("out_col", out_col, ec[idx]);
          check("out_last", out_last, (idx == n - 1));
        end
        if (idx == abort_idx) fin = 1;
        else if (out_ready) idx++;
      end
      if (done) begin
        check("done_elements", idx, n);
        check("done_reads", aidx, n);
        if (rmode == 0) check("done_latency", k, n + 2);
        fin = 1;
      end
    end
    if (!fin) check("timeout", 0, 1);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #2;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_read", mem_read, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; col_major = 1'b0; base_addr = '0; out_ready = 1'b0;
    foreach (mem[i]) mem[i] = 8'($urandom);
    mem[0] = 8'd5; mem[1] = 8'd6; mem[2] = 8'd7; mem[3] = 8'd8;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_out_data", out_data, 0);
    #10 rst = 1'b1;

    // Row-major then column-major from base 0 (values 5,6,7,8).
    run_matrix(6'd0, 1'b0, 0, 1'b0, -1);
    idle_cycle();
    run_matrix(6'd0, 1'b1, 0, 1'b0, -1);
    idle_cycle();

    // Toggling ready: held elements must stay stable, none lost or repeated.
    run_matrix(6'd0, 1'b0, 1, 1'b0, -1);
    idle_cycle();
    run_matrix(6'd0, 1'b1, 1, 1'b0, -1);
    idle_cycle();

    // Address wrap from base 62.
    run_matrix(6'd62, 1'b0, 0, 1'b0, -1);
    idle_cycle();

    // Reset during the third element's hold, then a clean read from (0,0).
    run_matrix(6'd0, 1'b0, 0, 1'b0, 2);
    rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_valid", out_valid, 0);
    check("arst_last", out_last, 0);
    check("arst_mem_read", mem_read, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_out_data", out_data, 0);
    check("arst_out_row", out_row, 0);
    check("arst_out_col", out_col, 0);
    #3 rst = 1'b1;
    run_matrix(6'd0, 1'b0, 0, 1'b0, -1);
    idle_cycle();

    // Start held high through DONE: one matrix per IDLE entry.
    run_matrix(6'd10, 1'b1, 0, 1'b1, -1);
    idle_cycle();
    run_matrix(6'd10, 1'b1, 0, 1'b1, -1);
    start = 1'b0;
    idle_cycle();

    // Randomised bases, orders and backpressure.
    for (int t = 0; t < 6; t++) begin
      run_matrix(AW'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 2, 1'b0, -1);
      idle_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
